// File: rtl/cache_fill_if.sv
// cache_fill_if: miss/memory/array signal bundle between a cache fill FSM and its surroundings
//   miss_detected, miss_address          lookup miss and the byte address that missed
//   memory_data, memory_data_valid       in-order read returns from main memory
//   fsm_busy                             fill in progress, pipeline stalls
//   memory_request, memory_address       one read request per cycle
//   write_data_array, fill_word, fill_data  data array word write
//   write_tag_array                      tag/valid write on the final word
//   master: the fill FSM; slave: the cache/memory side
interface cache_fill_if #(parameter int ADDR_WIDTH = 16);
   logic                  miss_detected;
   logic [ADDR_WIDTH-1:0] miss_address;
   logic [15:0]           memory_data;
   logic                  memory_data_valid;
   logic                  fsm_busy;
   logic                  memory_request;
   logic [ADDR_WIDTH-1:0] memory_address;
   logic                  write_data_array;
   logic [2:0]            fill_word;
   logic [15:0]           fill_data;
   logic                  write_tag_array;
   modport master (
      input  miss_detected, miss_address, memory_data, memory_data_valid,
      output fsm_busy, memory_request, memory_address, write_data_array, fill_word, fill_data,
             write_tag_array
   );
   modport slave (
      output miss_detected, miss_address, memory_data, memory_data_valid,
      input  fsm_busy, memory_request, memory_address, write_data_array, fill_word, fill_data,
             write_tag_array
   );
endinterface

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: fetches a missing 8-word block from pipelined memory and streams it into the cache arrays
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset; aborts any fill without a tag write
//   bus  cache_fill_if.master: miss input, memory request/return, data/tag array writes
module cache_fill_fsm #(
   parameter int ADDR_WIDTH  = 16,
   parameter int BLOCK_WORDS = 8
) (
   input logic         clk,
   input logic         rst,
   cache_fill_if.master bus
);
   typedef enum logic {IDLE, FILL} state_t;
   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [3:0]            req_cnt_q, req_cnt_d;
   logic [3:0]            rcv_cnt_q, rcv_cnt_d;
   logic                  busy, req, acc, last;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         base_q    <= '0;
         req_cnt_q <= '0;
         rcv_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         req_cnt_q <= req_cnt_d;
         rcv_cnt_q <= rcv_cnt_d;
      end
   end
   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      req_cnt_d = req_cnt_q;
      rcv_cnt_d = rcv_cnt_q;
      busy      = state_q == FILL;
      req       = busy && req_cnt_q < 4'(BLOCK_WORDS);
      // a valid with nothing outstanding is a protocol error and is dropped
      acc       = busy && bus.memory_data_valid && rcv_cnt_q < req_cnt_q;
      last      = acc && rcv_cnt_q == 4'(BLOCK_WORDS - 1);
      if (!busy && bus.miss_detected) begin
         state_d   = FILL;
         base_d    = bus.miss_address & ~ADDR_WIDTH'(15);
         req_cnt_d = '0;
         rcv_cnt_d = '0;
      end
      if (busy) begin
         req_cnt_d = req_cnt_q + {3'b0, req};
         rcv_cnt_d = rcv_cnt_q + {3'b0, acc};
         state_d   = last ? IDLE : FILL;
      end
   end
   assign bus.fsm_busy         = busy;
   assign bus.memory_request   = req;
   assign bus.memory_address   = busy ? base_q + ADDR_WIDTH'({req_cnt_q[2:0], 1'b0}) : '0;
   assign bus.write_data_array = acc;
   assign bus.fill_word        = acc ? rcv_cnt_q[2:0] : '0;
   assign bus.fill_data        = bus.memory_data;
   assign bus.write_tag_array  = last;
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: scoreboard bench with a latency-randomised in-order memory model
module tb_cache_fill_fsm;
   logic clk = 0;
   logic rst = 0;
   always #5 clk = ~clk;
   cache_fill_if #(.ADDR_WIDTH(16)) bus ();
   cache_fill_fsm #(.ADDR_WIDTH(16), .BLOCK_WORDS(8)) dut (.clk(clk), .rst(rst), .bus(bus));
   int checks = 0, failures = 0;
   int cyc = 0, e0 = 0, tag_cyc = 0, first_req_cyc = 0, fills = 0, words_rx = 0, last_rdy = 0, rdy;
   bit model_busy = 0, idle_seen = 1, fixed_lat = 1, spurious = 0, real_ret = 0, last;
   logic [15:0] exp_req[$], exp_data[$], pend_addr[$];
   int exp_word[$], pend_rdy[$];
   logic [15:0] cur_seed = 0, seed_next = 0, base_m, ra, last_req_addr = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask
   // reference: a sampled miss in an idle cycle expands into 8 block-ordered requests and 8 word writes
   always @(posedge clk) begin
      cyc++;
      if (!rst && bus.miss_detected && idle_seen && !model_busy) begin
         base_m   = bus.miss_address & 16'hFFF0;
         cur_seed = seed_next;
         seed_next = 16'($urandom);
         for (int i = 0; i < 8; i++) begin
            exp_req.push_back(16'(base_m + 16'(2 * i)));
            exp_word.push_back(i);
            exp_data.push_back(16'(cur_seed + 16'(i)));
         end
         model_busy = 1;
         e0 = cyc;
         fills++;
         words_rx = 0;
      end
   end
   // memory: returns in request order once each request's ready cycle arrives
   always @(posedge clk) begin
      #1;
      real_ret = 0;
      bus.memory_data_valid = 0;
      bus.memory_data = 16'($urandom);
      if (!rst) begin
         if (pend_rdy.size() != 0 && pend_rdy[0] <= cyc) begin
            ra = pend_addr.pop_front();
            void'(pend_rdy.pop_front());
            bus.memory_data_valid = 1;
            bus.memory_data = cur_seed + 16'(ra[3:1]);
            real_ret = 1;
         end else if (spurious && pend_rdy.size() == 0 && $urandom_range(0, 2) == 0)
            bus.memory_data_valid = 1;
      end
   end
   // monitor
   always @(negedge clk) begin
      if (!rst) begin
         idle_seen = !model_busy;
         chk("busy", 32'(bus.fsm_busy), 32'(model_busy));
         chk("req", 32'(bus.memory_request), 32'(exp_req.size() != 0));
         if (bus.memory_request && exp_req.size() != 0) begin
            if (exp_req.size() == 8) first_req_cyc = cyc;
            chk("addr", 32'(bus.memory_address), 32'(exp_req.pop_front()));
            last_req_addr = bus.memory_address;
            pend_addr.push_back(bus.memory_address);
            rdy = fixed_lat ? cyc + 4 : cyc + int'($urandom_range(1, 6));
            if (!fixed_lat && last_rdy + 1 > rdy) rdy = last_rdy + int'($urandom_range(1, 6));
            last_rdy = rdy;
            pend_rdy.push_back(rdy);
         end
         if (!model_busy) begin
            chk("idle_addr", 32'(bus.memory_address), 0);
            chk("idle_word", 32'(bus.fill_word), 0);
         end
         chk("wr", 32'(bus.write_data_array), 32'(real_ret));
         if (bus.write_data_array && real_ret && exp_word.size() != 0) begin
            chk("word", 32'(bus.fill_word), 32'(exp_word.pop_front()));
            chk("data", 32'(bus.fill_data), 32'(exp_data.pop_front()));
            last = exp_word.size() == 0;
            chk("tag", 32'(bus.write_tag_array), 32'(last));
            words_rx++;
            if (last) begin
               model_busy = 0;
               tag_cyc = cyc;
            end
         end else
            chk("tag_nowr", 32'(bus.write_tag_array), 0);
      end
   end
   task automatic chk_zero(input string nm);
      chk({nm, "_busy"}, 32'(bus.fsm_busy), 0);
      chk({nm, "_req"}, 32'(bus.memory_request), 0);
      chk({nm, "_wr"}, 32'(bus.write_data_array), 0);
      chk({nm, "_tag"}, 32'(bus.write_tag_array), 0);
      chk({nm, "_addr"}, 32'(bus.memory_address), 0);
      chk({nm, "_word"}, 32'(bus.fill_word), 0);
   endtask
   task automatic clear_model();
      exp_req.delete();
      exp_word.delete();
      exp_data.delete();
      pend_rdy.delete();
      pend_addr.delete();
      model_busy = 0;
      idle_seen = 1;
   endtask
   task automatic release_rst();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2 rst = 0;
   endtask
   task automatic issue_miss(input logic [15:0] a);
      @(posedge clk);
      #2;
      bus.miss_address = a;
      bus.miss_detected = 1;
      @(posedge clk);
      #2 bus.miss_detected = 0;
   endtask
   task automatic wait_idle();
      int n = 0;
      while (model_busy && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("fill_done", 32'(model_busy), 0);
   endtask
   task automatic wait_fills(input int target);
      int n = 0;
      while (fills < target && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("fill_start", 32'(fills), 32'(target));
   endtask
   int f0, t1, n;
   initial begin
      bus.miss_detected = 0;
      bus.miss_address = 0;
      #1 rst = 1;
      #1 chk_zero("reset");
      release_rst();
      spurious = 1;
      repeat (10) @(posedge clk);
      spurious = 0;
      fixed_lat = 1;
      seed_next = 16'hA000;
      issue_miss(16'h1236);
      wait_idle();
      chk("basic_tag_cycle", 32'(tag_cyc - e0), 11);
      chk("basic_first_req", 32'(first_req_cyc - e0), 0);
      issue_miss(16'hFFFF);
      wait_idle();
      chk("wrap_last_addr", 32'(last_req_addr), 32'h0000_FFFE);
      fixed_lat = 0;
      spurious = 1;
      repeat (6) begin
         issue_miss(16'($urandom));
         wait_idle();
         chk("rand_words", 32'(words_rx), 8);
      end
      spurious = 0;
      f0 = fills;
      @(posedge clk);
      #2;
      bus.miss_address = 16'h2345;
      bus.miss_detected = 1;
      wait_fills(f0 + 1);
      bus.miss_address = 16'h5670;
      wait_fills(f0 + 2);
      t1 = tag_cyc;
      bus.miss_detected = 0;
      wait_idle();
      chk("busy_miss_fills", 32'(fills - f0), 2);
      chk("busy_miss_gap", 32'(first_req_cyc - t1), 2);
      fixed_lat = 1;
      issue_miss(16'h8ABC);
      n = 0;
      while (words_rx < 3 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("abort_words", 32'(words_rx), 3);
      #2 rst = 1;
      #1 chk_zero("abort");
      clear_model();
      release_rst();
      issue_miss(16'h4000);
      wait_idle();
      chk("refill_words", 32'(words_rx), 8);
      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end
endmodule
